// File: rtl/fifo_wr_arb.sv
// Round-robin write arbiter in front of a FIFO. It tracks FIFO occupancy in a shadow
// counter so it never over-commits, and it runs a flush FSM that stops accepts and waits for the FIFO to drain.
module fifo_wr_arb #(
  parameter int NREQ  = 3,
  parameter int DW    = 4,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_b,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]   req_rdy,
  output logic              write_en,
  output logic [DW-1:0]     write_data,
  output logic [1:0]        grant_id,
  input  logic              read_en,
  input  logic              empty,
  input  logic              full,
  output logic [2:0]        occupancy,
  input  logic              flush_req,
  output logic              flush_done
);

  typedef enum logic [1:0] {IDLE, DRAIN, DONE} state_e;

  localparam logic [2:0] DEPTH_C = 3'(DEPTH);
  localparam logic [1:0] RR_INIT = 2'(NREQ - 1);

  state_e          state_q, state_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic            write_en_q, write_en_d;
  logic [DW-1:0]   write_data_q, write_data_d;
  logic [1:0]      grant_id_q, grant_id_d;
  logic [2:0]      occ_q, occ_d;

  logic [1:0]      win;
  logic            found;
  logic            credit_ok;
  logic            accept;
  logic            pop;

  // Search starts one past the last winner, so every steady requester is served within NREQ accepts.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_vld[(int'(rr_ptr_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = 2'((int'(rr_ptr_q) + k) % NREQ);
      end
    end
  end

  // A full flag blocks accepts as a second guard. With a consistent FIFO the credit check already excludes this case.
  assign credit_ok = (occ_q < DEPTH_C) && (state_q == IDLE);
  assign accept    = rst_b && credit_ok && !flush_req && !full && found;
  assign pop       = read_en && (!empty || write_en_q);

  always_comb begin
    req_rdy = '0;
    if (accept) req_rdy[win] = 1'b1;
  end

  always_comb begin
    write_en_d   = accept;
    write_data_d = write_data_q;
    grant_id_d   = grant_id_q;
    rr_ptr_d     = rr_ptr_q;
    if (accept) begin
      write_data_d = req_data[win*DW +: DW];
      grant_id_d   = win;
      rr_ptr_d     = win;
    end
    // The count includes the in-flight write. An accept and a pop in the same cycle cancel out.
    occ_d = occ_q;
    if (accept && !pop)                     occ_d = occ_q + 3'd1;
    else if (!accept && pop && occ_q != '0) occ_d = occ_q - 3'd1;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (flush_req) state_d = DRAIN;
      DRAIN:   if (occ_q == '0 && !write_en_q) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q      <= IDLE;
      rr_ptr_q     <= RR_INIT;
      write_en_q   <= 1'b0;
      write_data_q <= '0;
      grant_id_q   <= '0;
      occ_q        <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      write_en_q   <= write_en_d;
      write_data_q <= write_data_d;
      grant_id_q   <= grant_id_d;
      occ_q        <= occ_d;
    end
  end

  assign write_en   = write_en_q;
  assign write_data = write_data_q;
  assign grant_id   = grant_id_q;
  assign occupancy  = occ_q;
  assign flush_done = (state_q == DONE);

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Directed bench for fifo_wr_arb. A small FIFO model drives empty/full, and each cycle
// checks the accept strobe, registered write outputs, occupancy and flush_done.
module tb_fifo_wr_arb;
  localparam int NREQ  = 3;
  localparam int DW    = 4;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst_b = 1'b0;
  logic [NREQ-1:0]   req_vld = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   req_rdy;
  logic              write_en;
  logic [DW-1:0]     write_data;
  logic [1:0]        grant_id;
  logic              read_en = 1'b0;
  logic              empty;
  logic              full;
  logic [2:0]        occupancy;
  logic              flush_req = 1'b0;
  logic              flush_done;

  int checks   = 0;
  int failures = 0;
  int fifo_cnt;

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(NREQ), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_b      (rst_b),
    .req_vld    (req_vld),
    .req_data   (req_data),
    .req_rdy    (req_rdy),
    .write_en   (write_en),
    .write_data (write_data),
    .grant_id   (grant_id),
    .read_en    (read_en),
    .empty      (empty),
    .full       (full),
    .occupancy  (occupancy),
    .flush_req  (flush_req),
    .flush_done (flush_done)
  );

  // Downstream FIFO model: a read with a same-cycle write is a passthrough when empty.
  assign empty = (fifo_cnt == 0);
  assign full  = (fifo_cnt == DEPTH);
  always @(posedge clk or negedge rst_b) begin
    if (!rst_b) fifo_cnt <= 0;
    else        fifo_cnt <= fifo_cnt + int'(write_en)
                            - int'(read_en && (fifo_cnt != 0 || write_en));
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    #3;
    if (rst_b) check("no_write_when_full", 32'(write_en && full && !read_en), 32'd0);
  end

  // Apply one cycle of inputs at the falling edge, then check outputs before the next rising edge.
  task automatic step(input string tag, input logic rst, input logic [2:0] v, input logic [11:0] d,
                      input logic rd, input logic fl,
                      input logic [2:0] e_rdy, input logic e_we, input logic [3:0] e_wd,
                      input logic [1:0] e_gid, input logic [2:0] e_occ, input logic e_fd);
    @(negedge clk);
    rst_b = rst; req_vld = v; req_data = d; read_en = rd; flush_req = fl;
    #1;
    check({tag, ".req_rdy"},    32'(req_rdy),    32'(e_rdy));
    check({tag, ".write_en"},   32'(write_en),   32'(e_we));
    check({tag, ".write_data"}, 32'(write_data), 32'(e_wd));
    check({tag, ".grant_id"},   32'(grant_id),   32'(e_gid));
    check({tag, ".occupancy"},  32'(occupancy),  32'(e_occ));
    check({tag, ".flush_done"}, 32'(flush_done), 32'(e_fd));
  endtask

  initial begin
    //    tag    rst v       data     rd fl   rdy     we wd   gid occ fd
    step("rst0", 0, 3'b111, 12'h321, 0, 0,  3'b000, 0, 4'h0, 0, 0, 0);
    step("rst1", 0, 3'b111, 12'h321, 0, 0,  3'b000, 0, 4'h0, 0, 0, 0);
    // Fill from reset: grants 0,1,2,0 then credit runs out
    step("c1",   1, 3'b111, 12'h321, 0, 0,  3'b001, 0, 4'h0, 0, 0, 0);
    step("c2",   1, 3'b111, 12'h321, 0, 0,  3'b010, 1, 4'h1, 0, 1, 0);
    step("c3",   1, 3'b111, 12'h321, 0, 0,  3'b100, 1, 4'h2, 1, 2, 0);
    step("c4",   1, 3'b111, 12'h321, 0, 0,  3'b001, 1, 4'h3, 2, 3, 0);
    step("c5",   1, 3'b111, 12'h321, 0, 0,  3'b000, 1, 4'h1, 0, 4, 0);
    step("c6",   1, 3'b111, 12'h321, 0, 0,  3'b000, 0, 4'h1, 0, 4, 0);
    // One pop frees one credit, used on the following cycle
    step("c7",   1, 3'b111, 12'h321, 1, 0,  3'b000, 0, 4'h1, 0, 4, 0);
    step("c8",   1, 3'b111, 12'h321, 0, 0,  3'b010, 0, 4'h1, 0, 3, 0);
    step("c9",   1, 3'b000, 12'h321, 1, 0,  3'b000, 1, 4'h2, 1, 4, 0);
    step("c10",  1, 3'b000, 12'h321, 1, 0,  3'b000, 0, 4'h2, 1, 3, 0);
    // Flush pulse at occupancy 2 with continuous reads
    step("c11",  1, 3'b111, 12'h321, 1, 1,  3'b000, 0, 4'h2, 1, 2, 0);
    step("c12",  1, 3'b111, 12'h321, 1, 0,  3'b000, 0, 4'h2, 1, 1, 0);
    step("c13",  1, 3'b111, 12'h321, 1, 0,  3'b000, 0, 4'h2, 1, 0, 0);
    step("c14",  1, 3'b111, 12'h321, 1, 0,  3'b000, 0, 4'h2, 1, 0, 1);
    step("c15",  1, 3'b000, 12'h321, 0, 0,  3'b000, 0, 4'h2, 1, 0, 0);
    // Single requester 1 with data A; other lanes carry data that must be ignored
    step("c16",  1, 3'b010, 12'hFA5, 0, 0,  3'b010, 0, 4'h2, 1, 0, 0);
    // Passthrough: FIFO empty, read plus accept leaves occupancy unchanged
    step("c17",  1, 3'b001, 12'hFA5, 1, 0,  3'b001, 1, 4'hA, 1, 1, 0);
    step("c18",  1, 3'b100, 12'hFA5, 0, 0,  3'b100, 1, 4'h5, 0, 1, 0);
    // Reset right after an accept discards the in-flight write
    step("c19",  0, 3'b111, 12'hFA5, 0, 0,  3'b000, 0, 4'h0, 0, 0, 0);
    step("c20",  1, 3'b111, 12'hFA5, 0, 0,  3'b001, 0, 4'h0, 0, 0, 0);
    step("c21",  1, 3'b000, 12'hFA5, 0, 0,  3'b000, 1, 4'h5, 0, 1, 0);
    // flush_req held high: DONE -> IDLE -> DRAIN re-entry, no accepts
    step("c22",  1, 3'b111, 12'hFA5, 1, 1,  3'b000, 0, 4'h5, 0, 1, 0);
    step("c23",  1, 3'b111, 12'hFA5, 1, 1,  3'b000, 0, 4'h5, 0, 0, 0);
    step("c24",  1, 3'b111, 12'hFA5, 1, 1,  3'b000, 0, 4'h5, 0, 0, 1);
    step("c25",  1, 3'b111, 12'hFA5, 1, 1,  3'b000, 0, 4'h5, 0, 0, 0);
    step("c26",  1, 3'b111, 12'hFA5, 1, 1,  3'b000, 0, 4'h5, 0, 0, 0);
    step("c27",  1, 3'b111, 12'hFA5, 0, 0,  3'b000, 0, 4'h5, 0, 0, 1);
    step("c28",  1, 3'b111, 12'hFA5, 0, 0,  3'b010, 0, 4'h5, 0, 0, 0);
    step("c29",  1, 3'b000, 12'hFA5, 0, 0,  3'b000, 1, 4'hA, 1, 1, 0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arb.md
FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

Interface
REQ-001 SHALL have parameters: NREQ, 3, number of write requesters; DW, 4, data width; DEPTH, 4, downstream FIFO depth.
REQ-002 SHALL have ports:
- clk  in  1  clock, rising edge.
- rst_b  in  1  reset, asynchronous, active-low.
- req_vld  in  NREQ  per-requester write request.
- req_data  in  NREQ*DW  per-requester data; requester i occupies bits [i*DW +: DW].
- req_rdy  out  NREQ  one-hot accept strobe, combinational.
- write_en  out  1  FIFO write strobe, registered.
- write_data  out  DW  FIFO write data, registered.
- grant_id  out  2  index of the requester whose data is on write_data.
- read_en  in  1  FIFO read request, observed only.
- empty  in  1  FIFO empty flag.
- full  in  1  FIFO full flag.
- occupancy  out  3  shadow count of FIFO entries plus the in-flight write.
- flush_req  in  1  level request to drain the FIFO.
- flush_done  out  1  one-cycle pulse when the drain completes.

Function
REQ-003 SHALL define pop = read_en && (!empty || write_en), matching the FIFO's effective read.
REQ-004 SHALL define credit_ok = (occupancy < DEPTH) && (state == IDLE); there is no same-cycle credit reuse on a pop.
REQ-005 SHALL accept at most one requester per cycle, and only when credit_ok = 1.
REQ-006 SHALL arbitrate round-robin: search from (rr_ptr + 1) mod NREQ upward with wrap; the first requester with req_vld = 1 wins.
REQ-007 SHALL assert req_rdy[w] combinationally in the accept cycle for winner w; every other req_rdy bit SHALL be 0.
REQ-008 SHALL update rr_ptr to w only on an accept; rr_ptr SHALL hold when there is no accept.
REQ-009 SHALL, on an accept, drive write_en = 1, write_data = req_data[w], and grant_id = w in the next cycle (latency 1).
REQ-010 SHALL drive write_en = 0 in cycles following a non-accept, and SHALL hold write_data and grant_id at their last values.
REQ-011 SHALL update occupancy each cycle as occupancy + accept - pop; the result SHALL never exceed DEPTH or go below 0.
REQ-012 SHALL guarantee write_en is never 1 while full = 1 and read_en = 0.
REQ-013 SHALL bound starvation: any requester holding req_vld steadily SHALL be accepted within NREQ accepts.
REQ-014 SHALL implement the flush state machine with states IDLE, DRAIN, DONE.
REQ-015 SHALL transition IDLE -> DRAIN when flush_req = 1; no accepts occur from that same cycle onward.
REQ-016 SHALL transition DRAIN -> DONE when occupancy == 0 and write_en == 0.
REQ-017 SHALL, in DONE, assert flush_done for one cycle and then go to IDLE.
REQ-018 SHALL, if flush_req is still 1 when returning to IDLE, re-enter DRAIN on the next cycle.
REQ-019 SHALL ignore flush_req while in DRAIN or DONE.
REQ-020 SHALL treat an in-flight write (accepted before DRAIN entry) as occupancy until it is popped.
REQ-021 SHALL treat a simultaneous accept and pop as a net occupancy change of 0.
REQ-022 SHALL ignore req_data of requesters that are not granted.

Reset
REQ-023 SHALL, while rst_b = 0, force req_rdy = 0, write_en = 0, write_data = 0, grant_id = 0, occupancy = 0, flush_done = 0, state = IDLE, and rr_ptr = NREQ-1, so that requester 0 has first priority.
REQ-024 SHALL, when reset asserts mid-operation, discard any in-flight write (write_en = 0 immediately) and SHALL resume accepts on the first clock after rst_b rises.

Verification
REQ-025 SHALL cover: after reset, all req_vld = 1 with read_en = 0 -> accepts 0,1,2,0; occupancy = 4; req_rdy = 0 thereafter; write_en never 1 with full = 1.
REQ-026 SHALL cover: occupancy = 4, read_en = 1 for one cycle -> occupancy 3 the next cycle, one accept on the following cycle, then occupancy back to 4.
REQ-027 SHALL cover: only req_vld[1] = 1 with data 4'hA -> req_rdy = 3'b010; the next cycle shows write_en = 1, write_data = 4'hA, grant_id = 1.
REQ-028 SHALL cover: occupancy = 2, flush_req pulsed, read_en = 1 continuously -> no accepts; occupancy 2 -> 1 -> 0; flush_done high for one cycle; state returns to IDLE.
REQ-029 SHALL cover: rst_b asserted on the cycle after an accept -> write_en = 0 asynchronously and occupancy = 0; the first post-reset grant goes to requester 0.
REQ-030 SHALL cover: FIFO empty with accept and read_en in the same cycle (passthrough pop) -> occupancy unchanged.
